// File: rtl/sfr_periph_writer_if.sv
// Peripheral write-request bus and SFR write-port signals shared by
// sfr_periph_writer and whatever drives its requesters.
interface sfr_periph_writer_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [5*NUM_REQ-1:0] req_addr;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 cpu_wr_busy;
  logic [1:0]           sfr_wren;
  logic [4:0]           sfr_wr_addr;
  logic [7:0]           sfr_write_data;
  logic                 lock_err;
  logic [2:0]           lock_err_id;

  modport master (
    output req_valid, req_addr, req_data, cpu_wr_busy,
    input  req_ready, sfr_wren, sfr_wr_addr, sfr_write_data, lock_err, lock_err_id
  );

  modport slave (
    input  req_valid, req_addr, req_data, cpu_wr_busy,
    output req_ready, sfr_wren, sfr_wr_addr, sfr_write_data, lock_err, lock_err_id
  );
endinterface

// File: rtl/sfr_periph_writer.sv
// Round-robin arbiter that serialises peripheral SFR writes onto the SFR file
// write port, yielding to the CPU and refusing writes to CPU-only registers.
module sfr_periph_writer #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned LOCK_LIMIT = 8
) (
  input logic                clock,
  input logic                nreset,
  sfr_periph_writer_if.slave bus
);
  localparam int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned ADDR_W1 = ADDR_W + 1;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ID_W    = 3;
  localparam logic [ADDR_W1-1:0] LOCK_LIM = ADDR_W1'(LOCK_LIMIT);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  state_t              r_state;
  logic [PTR_W-1:0]    r_rr_ptr;
  logic [ADDR_W-1:0]   r_hold_addr;
  logic [DATA_W-1:0]   r_hold_data;
  logic [PTR_W-1:0]    r_hold_id;
  logic [1:0]          r_wren;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data;
  logic                r_lock_err;
  logic [ID_W-1:0]     r_lock_err_id;

  state_t              w_state_nxt;
  logic [PTR_W-1:0]    w_rr_nxt;
  logic [ADDR_W-1:0]   w_hold_addr_nxt;
  logic [DATA_W-1:0]   w_hold_data_nxt;
  logic [PTR_W-1:0]    w_hold_id_nxt;
  logic [1:0]          w_wren_nxt;
  logic [ADDR_W-1:0]   w_wr_addr_nxt;
  logic [DATA_W-1:0]   w_wr_data_nxt;
  logic                w_lock_err_nxt;
  logic [ID_W-1:0]     w_lock_err_id_nxt;

  logic [ADDR_W-1:0]   w_addr_arr [NUM_REQ];
  logic [DATA_W-1:0]   w_data_arr [NUM_REQ];
  logic [PTR_W-1:0]    w_scan_idx;
  logic [PTR_W-1:0]    w_gnt;
  logic                w_gnt_found;
  logic                w_xfer;
  logic                w_locked;

  function automatic logic [PTR_W-1:0] f_next_ptr(input logic [PTR_W-1:0] p);
    if (32'(p) == NUM_REQ - 1) return '0;
    return p + PTR_W'(1);
  endfunction

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_addr_arr[gi] = bus.req_addr[ADDR_W*gi +: ADDR_W];
    assign w_data_arr[gi] = bus.req_data[DATA_W*gi +: DATA_W];
  end

  // First valid requester at or after the round-robin pointer, with wrap.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt       = '0;
    w_scan_idx  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_scan_idx = PTR_W'((32'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_gnt_found && bus.req_valid[w_scan_idx]) begin
        w_gnt_found = 1'b1;
        w_gnt       = w_scan_idx;
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (r_state == ST_IDLE && !bus.cpu_wr_busy && !nreset && w_gnt_found)
      bus.req_ready[w_gnt] = 1'b1;
  end

  assign w_xfer   = |(bus.req_valid & bus.req_ready);
  assign w_locked = {1'b0, w_addr_arr[w_gnt]} < LOCK_LIM;

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt       = r_state;
    w_rr_nxt          = r_rr_ptr;
    w_hold_addr_nxt   = r_hold_addr;
    w_hold_data_nxt   = r_hold_data;
    w_hold_id_nxt     = r_hold_id;
    w_wren_nxt        = 2'b00;
    w_wr_addr_nxt     = r_wr_addr;
    w_wr_data_nxt     = r_wr_data;
    w_lock_err_nxt    = 1'b0;
    w_lock_err_id_nxt = r_lock_err_id;
    case (r_state)
      ST_IDLE: begin
        if (w_xfer) begin
          if (w_locked) begin
            w_lock_err_nxt    = 1'b1;
            w_lock_err_id_nxt = ID_W'(w_gnt);
            w_rr_nxt          = f_next_ptr(w_gnt);
          end else begin
            w_hold_addr_nxt = w_addr_arr[w_gnt];
            w_hold_data_nxt = w_data_arr[w_gnt];
            w_hold_id_nxt   = w_gnt;
            w_state_nxt     = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (!bus.cpu_wr_busy) begin
          w_wren_nxt    = 2'b01;
          w_wr_addr_nxt = r_hold_addr;
          w_wr_data_nxt = r_hold_data;
          w_rr_nxt      = f_next_ptr(r_hold_id);
          w_state_nxt   = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (nreset) begin
      r_state       <= ST_IDLE;
      r_rr_ptr      <= '0;
      r_hold_addr   <= '0;
      r_hold_data   <= '0;
      r_hold_id     <= '0;
      r_wren        <= 2'b00;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      r_lock_err    <= 1'b0;
      r_lock_err_id <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_rr_ptr      <= w_rr_nxt;
      r_hold_addr   <= w_hold_addr_nxt;
      r_hold_data   <= w_hold_data_nxt;
      r_hold_id     <= w_hold_id_nxt;
      r_wren        <= w_wren_nxt;
      r_wr_addr     <= w_wr_addr_nxt;
      r_wr_data     <= w_wr_data_nxt;
      r_lock_err    <= w_lock_err_nxt;
      r_lock_err_id <= w_lock_err_id_nxt;
    end
  end

  assign bus.sfr_wren       = r_wren;
  assign bus.sfr_wr_addr    = r_wr_addr;
  assign bus.sfr_write_data = r_wr_data;
  assign bus.lock_err       = r_lock_err;
  assign bus.lock_err_id    = r_lock_err_id;

endmodule

// File: tb/tb_sfr_periph_writer.sv
// Scoreboard bench for sfr_periph_writer: directed scenarios followed by
// randomized traffic, checked against a transaction-level arbiter model.
module tb_sfr_periph_writer;
  localparam int unsigned N    = 4;
  localparam int unsigned LOCK = 8;

  logic clock = 1'b0;
  logic nreset;
  sfr_periph_writer_if #(.NUM_REQ(N)) bus ();

  sfr_periph_writer #(.NUM_REQ(N), .LOCK_LIMIT(LOCK)) dut (
    .clock  (clock),
    .nreset (nreset),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Requester stimulus state.
  logic       rq_v [N];
  logic [4:0] rq_a [N];
  logic [7:0] rq_d [N];
  logic       consumed [N];
  logic       busy;
  int         mode;   // 0: drop after accept, 1: repost same, 2: random

  // Reference model and scoreboard queues.
  int          m_rr;
  int          m_issue;
  int          m_hold_id;
  logic [12:0] wr_q[$];
  int          due_q[$];
  int          err_q[$];
  int          err_due_q[$];
  logic [4:0]  last_addr;
  logic [7:0]  last_data;
  int          last_id;
  logic        rst_seen;
  logic        chk_rst;
  logic        mon_en;
  int          wr_log[$];
  int          wr_cyc_log[$];
  int          acc_log[$];
  int          elog[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]       = rq_v[i];
      bus.req_addr[5*i +: 5] = rq_a[i];
      bus.req_data[8*i +: 8] = rq_d[i];
    end
    bus.cpu_wr_busy = busy;
  endtask

  task automatic model_reset();
    m_rr = 0; m_issue = 0; m_hold_id = 0;
    wr_q.delete(); due_q.delete(); err_q.delete(); err_due_q.delete();
    last_addr = '0; last_data = '0; last_id = 0;
    rst_seen = 1'b0; chk_rst = 1'b1; mon_en = 1'b1;
  endtask

  // Predict this cycle's grant and queue the responses it must produce.
  task automatic model_cycle();
    logic [N-1:0] exp_rdy;
    int g;
    exp_rdy = '0;
    g = -1;
    for (int i = 0; i < N; i++) consumed[i] = 1'b0;
    if (nreset) begin
      check("ready_in_reset", int'(bus.req_ready), 0);
      rst_seen = 1'b1;
      return;
    end
    if (m_issue == 0 && !busy) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_rr + k) % N;
        if (g < 0 && rq_v[idx]) g = idx;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", int'(bus.req_ready), int'(exp_rdy));
    if (m_issue == 1) begin
      if (!busy) begin
        due_q.push_back(cyc + 1);
        m_rr = (m_hold_id + 1) % N;
        m_issue = 0;
      end
    end else if (g >= 0) begin
      consumed[g] = 1'b1;
      acc_log.push_back(cyc);
      if (rq_a[g] >= LOCK) begin
        wr_q.push_back({rq_a[g], rq_d[g]});
        m_hold_id = g;
        m_issue = 1;
      end else begin
        err_q.push_back(g);
        err_due_q.push_back(cyc + 1);
        m_rr = (g + 1) % N;
      end
    end
  endtask

  task automatic step();
    @(negedge clock);
    if (chk_rst) begin
      check("rst_wren", int'(bus.sfr_wren), 0);
      check("rst_addr", int'(bus.sfr_wr_addr), 0);
      check("rst_data", int'(bus.sfr_write_data), 0);
      check("rst_lock_err", int'(bus.lock_err), 0);
      check("rst_lock_id", int'(bus.lock_err_id), 0);
      chk_rst = 1'b0;
    end
    model_cycle();
    @(posedge clock);
    #1;
    if (rst_seen) model_reset();
    for (int i = 0; i < N; i++) begin
      if (consumed[i] && mode != 1) rq_v[i] = 1'b0;
      if (mode == 2 && !rq_v[i] && $urandom_range(0, 3) == 0) begin
        rq_v[i] = 1'b1;
        rq_a[i] = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(8, 31));
        rq_d[i] = 8'($urandom);
      end
    end
    if (mode == 2) busy = ($urandom_range(0, 3) == 0);
    apply();
  endtask

  function automatic logic pending();
    logic any;
    any = (m_issue != 0) || (wr_q.size() != 0) || (err_q.size() != 0);
    for (int i = 0; i < N; i++) any = any | rq_v[i];
    return any;
  endfunction

  task automatic drain(input string name);
    int n;
    n = 0;
    while (pending() && n < 200) begin
      step();
      n++;
    end
    step();
    check({name, "_drained"}, int'(n < 200), 1);
  endtask

  task automatic post(input int i, input int a, input int d);
    rq_v[i] = 1'b1;
    rq_a[i] = 5'(a);
    rq_d[i] = 8'(d);
    apply();
  endtask

  task automatic clear_logs();
    wr_log.delete(); wr_cyc_log.delete(); acc_log.delete(); elog.delete();
  endtask

  task automatic wait_issue(input string name);
    int n;
    n = 0;
    while (m_issue == 0 && n < 50) begin
      step();
      n++;
    end
    check({name, "_accepted"}, int'(n < 50), 1);
  endtask

  // Monitor: pops expected writes and refusals whenever the DUT shows them.
  logic        mon_exp;
  logic [12:0] mon_e;
  always @(negedge clock) begin
    if (mon_en) begin
      check("wren_code", int'(bus.sfr_wren == 2'b10 || bus.sfr_wren == 2'b11), 0);
      mon_exp = (due_q.size() > 0 && due_q[0] == cyc);
      check("wr_strobe", int'(bus.sfr_wren == 2'b01), int'(mon_exp));
      if (mon_exp) void'(due_q.pop_front());
      if (bus.sfr_wren == 2'b01) begin
        wr_log.push_back(int'(bus.sfr_wr_addr));
        wr_cyc_log.push_back(cyc);
        if (wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_unexpected: got addr %0h data %0h expected no write", bus.sfr_wr_addr, bus.sfr_write_data);
        end else begin
          mon_e = wr_q.pop_front();
          last_addr = mon_e[12:8];
          last_data = mon_e[7:0];
        end
      end
      check("wr_addr", int'(bus.sfr_wr_addr), int'(last_addr));
      check("wr_data", int'(bus.sfr_write_data), int'(last_data));
      mon_exp = (err_due_q.size() > 0 && err_due_q[0] == cyc);
      check("lock_err", int'(bus.lock_err), int'(mon_exp));
      if (mon_exp) void'(err_due_q.pop_front());
      if (bus.lock_err) begin
        elog.push_back(int'(bus.lock_err_id));
        if (err_q.size() > 0) last_id = err_q.pop_front();
      end
      check("lock_err_id", int'(bus.lock_err_id), last_id);
    end
  end

  initial begin
    mon_en = 1'b0; chk_rst = 1'b0; rst_seen = 1'b0; mode = 0; busy = 1'b0;
    m_rr = 0; m_issue = 0; m_hold_id = 0;
    for (int i = 0; i < N; i++) begin
      rq_v[i] = 1'b0; rq_a[i] = '0; rq_d[i] = '0; consumed[i] = 1'b0;
    end
    nreset = 1'b1;
    apply();
    step();
    nreset = 1'b0;

    // Round-robin from reset: 20,21,22,23,20 two cycles apart.
    clear_logs();
    mode = 1;
    for (int i = 0; i < N; i++) post(i, 20 + i, 16 * i + 1);
    for (int c = 0; c < 11; c++) step();
    mode = 0;
    for (int i = 0; i < N; i++) rq_v[i] = 1'b0;
    apply();
    drain("rr");
    check("rr_count_min", int'(wr_log.size() >= 5), 1);
    if (wr_log.size() >= 5) begin
      for (int k = 0; k < 5; k++) check("rr_order", wr_log[k], 20 + (k % 4));
      for (int k = 1; k < 5; k++) check("rr_spacing", wr_cyc_log[k] - wr_cyc_log[k-1], 2);
    end

    // Single write with two-cycle latency.
    clear_logs();
    post(2, 12, 8'hA5);
    drain("single");
    check("single_count", wr_log.size(), 1);
    if (wr_log.size() == 1 && acc_log.size() == 1) begin
      check("single_addr", wr_log[0], 12);
      check("single_latency", wr_cyc_log[0] - acc_log[0], 2);
    end

    // CPU contention: three busy cycles while in ISSUE.
    clear_logs();
    post(0, 17, 8'h3C);
    wait_issue("stall");
    post(1, 18, 8'h11);
    busy = 1'b1; apply();
    for (int c = 0; c < 3; c++) step();
    busy = 1'b0; apply();
    drain("stall");
    check("stall_count", wr_log.size(), 2);
    if (wr_log.size() == 2 && acc_log.size() >= 1) begin
      check("stall_addr", wr_log[0], 17);
      check("stall_latency", wr_cyc_log[0] - acc_log[0], 5);
    end

    // Lock refusal, then pointer moved past requester 1.
    clear_logs();
    post(1, 3, 8'h5A);
    drain("lock");
    check("lock_no_write", wr_log.size(), 0);
    check("lock_err_count", elog.size(), 1);
    if (elog.size() == 1) check("lock_id", elog[0], 1);
    clear_logs();
    post(1, 10, 8'h01);
    post(2, 9, 8'h02);
    drain("lock_rr");
    check("lock_rr_count", wr_log.size(), 2);
    if (wr_log.size() == 2) check("lock_rr_first", wr_log[0], 9);

    // Boundary addresses and pointer wrap from 3 to 0.
    clear_logs();
    post(3, LOCK, 8'hC8);
    drain("bnd_lo");
    post(3, 31, 8'hFF);
    drain("bnd_hi");
    post(0, 14, 8'h40);
    post(3, 15, 8'h43);
    drain("wrap");
    check("bnd_count", wr_log.size(), 4);
    if (wr_log.size() == 4) begin
      check("bnd_lock_limit", wr_log[0], LOCK);
      check("bnd_31", wr_log[1], 31);
      check("wrap_first", wr_log[2], 14);
    end
    check("bnd_no_err", elog.size(), 0);

    // Reset while a write is held in ISSUE.
    post(1, 25, 8'h77);
    wait_issue("rst");
    rq_v[1] = 1'b0;
    busy = 1'b1; nreset = 1'b1; apply();
    step();
    nreset = 1'b0; busy = 1'b0; apply();
    clear_logs();
    for (int i = 0; i < N; i++) post(i, 16 + i, 8'h90 + i);
    drain("post_rst");
    check("post_rst_count", wr_log.size(), 4);
    if (wr_log.size() == 4) check("post_rst_first", wr_log[0], 16);

    // Randomized traffic.
    mode = 2;
    for (int c = 0; c < 600; c++) step();
    mode = 0;
    busy = 1'b0;
    apply();
    drain("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
